// File: rtl/ysyx_25040129_lsu_axi.sv
// LSU AXI-lite bus master: one outstanding load (AR->R) or store (AW+W->B) per core request.
// Optional `LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without touching the bus.
module ysyx_25040129_lsu_axi #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [1:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_t;

  state_t            state_q, state_n;
  logic              aw_done_q, aw_done_n;
  logic              w_done_q, w_done_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        wstrb_q;
  logic              misalign_c;
  logic              accept_c;
  logic [DATA_W-1:0] load_ext_c;

  assign accept_c = (state_q == IDLE) && req_valid;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_c = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Bus address/data come straight from the latched request registers
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wstrb_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      aw_done_q <= aw_done_n;
      w_done_q  <= w_done_n;
    end
  end

  // Next-state logic; AW and W handshakes are tracked independently
  always_comb begin
    state_n   = state_q;
    aw_done_n = aw_done_q;
    w_done_n  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          if (misalign_c)   state_n = RSP;
          else if (req_wen) state_n = WR_REQ;
          else              state_n = RD_ADDR;
        end
      end
      RD_ADDR: if (arready) state_n = RD_DATA;
      RD_DATA: if (rvalid)  state_n = RSP;
      WR_REQ: begin
        if (awvalid && awready) aw_done_n = 1'b1;
        if (wvalid && wready)   w_done_n  = 1'b1;
        if (aw_done_n && w_done_n) state_n = WR_RESP;
      end
      WR_RESP: if (bvalid)    state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state so each valid drops right after its beat
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      req_ready <= (state_n == IDLE);
      arvalid   <= (state_n == RD_ADDR);
      rready    <= (state_n == RD_DATA);
      awvalid   <= (state_n == WR_REQ) && !aw_done_n;
      wvalid    <= (state_n == WR_REQ) && !w_done_n;
      bready    <= (state_n == WR_RESP);
      rsp_valid <= (state_n == RSP);
    end
  end

  // Load data extraction and sign/zero extension
  always_comb begin
    load_ext_c = rdata;
    unique case (size_q)
      2'b00:   load_ext_c = {{(DATA_W-8){~uns_q & rdata[7]}}, rdata[7:0]};
      2'b01:   load_ext_c = {{(DATA_W-16){~uns_q & rdata[15]}}, rdata[15:0]};
      default: load_ext_c = rdata;
    endcase
  end

  // Request latch and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      wstrb_q   <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept_c) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        unique case (req_size)
          2'b00:   wstrb_q <= 2'b01;
          2'b01:   wstrb_q <= 2'b10;
          default: wstrb_q <= 2'b11;
        endcase
        if (misalign_c) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if ((state_q == RD_DATA) && rvalid) begin
        rsp_rdata <= load_ext_c;
        rsp_err   <= (rresp != 2'b00);
      end
      if ((state_q == WR_RESP) && bvalid) begin
        rsp_rdata <= '0;
        rsp_err   <= (bresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_lsu_axi.sv
// Scoreboard bench for ysyx_25040129_lsu_axi with a stall-configurable AXI-lite slave model.
module tb_ysyx_25040129_lsu_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, wstrb, bresp;

  always #5 clk = ~clk;

  ysyx_25040129_lsu_axi dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  typedef struct packed { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;

  // Monitor: compare every accepted response against the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  // Slave knobs and observations
  int ar_wait = 0, aw_wait = 0, w_wait = 0;
  int ar_beats = 0, aw_beats = 0, w_beats = 0;
  logic r_stall = 1'b0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;
  logic [31:0] ar_seen, aw_seen, w_seen;
  logic [1:0]  strb_seen;

  initial begin : ar_slave
    int cnt;
    logic [31:0] prev;
    arready = 1'b0; cnt = 0; prev = '0;
    forever begin
      @(posedge clk); #1;
      if (arready) begin
        ar_beats++; ar_seen = araddr; arready = 1'b0; cnt = 0;
      end else if (arvalid) begin
        if (cnt > 0) check("araddr_stable", araddr, prev);
        prev = araddr;
        if (cnt >= ar_wait) arready = 1'b1; else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : aw_slave
    int cnt;
    awready = 1'b0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (awready) begin
        aw_beats++; aw_seen = awaddr; awready = 1'b0; cnt = 0;
      end else if (awvalid) begin
        if (cnt >= aw_wait) awready = 1'b1; else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : w_slave
    int cnt;
    wready = 1'b0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (wready) begin
        w_beats++; w_seen = wdata; strb_seen = wstrb; wready = 1'b0; cnt = 0;
      end else if (wvalid) begin
        if (cnt >= w_wait) wready = 1'b1; else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : r_slave
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (rvalid) rvalid = 1'b0;
      else if (rready && !r_stall) begin rvalid = 1'b1; rdata = r_data; rresp = r_resp; end
    end
  end

  initial begin : b_slave
    bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      if (bvalid) bvalid = 1'b0;
      else if (bready) begin bvalid = 1'b1; bresp = b_resp; end
    end
  end

  // Issue one request, push its expected response, then retire it after 'hold' stalled cycles
  task automatic run(input string name, input logic [31:0] a, input logic wen, input logic [1:0] sz,
                     input logic uns, input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input int exp_lat, input int hold);
    int n;
    logic [31:0] held;
    exp_q.push_back({exp_rd, exp_err});
    req_addr = a; req_wen = wen; req_size = sz; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = (hold > 0);
    n = 1;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) check({name, "_rsp_timeout"}, 32'd0, 32'd1);
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    held = rsp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      check({name, "_hold_rdata"}, rsp_rdata, held);
      check({name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      check({name, "_hold_rsp_valid"}, 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int b0, a0, w0, n;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0; req_wen = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_valids", {25'd0, arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err}, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: word load, zero-wait slave
    r_data = 32'hDEADBEEF; b0 = ar_beats;
    run("ld_word", 32'h80000010, 1'b0, 2'b10, 1'b0, '0, 32'hDEADBEEF, 1'b0, 3, 0);
    check("ld_word_araddr", ar_seen, 32'h80000010);
    check("ld_word_beats", 32'(ar_beats - b0), 32'd1);

    // 2: byte/half extension and reserved size
    r_data = 32'h000000F0;
    run("ld_byte_s", 32'h80000020, 1'b0, 2'b00, 1'b0, '0, 32'hFFFFFFF0, 1'b0, 3, 0);
    run("ld_byte_u", 32'h80000021, 1'b0, 2'b00, 1'b1, '0, 32'h000000F0, 1'b0, 3, 0);
    r_data = 32'h1234F00D;
    run("ld_half_u", 32'h80000022, 1'b0, 2'b01, 1'b1, '0, 32'h0000F00D, 1'b0, 3, 0);
    run("ld_half_s", 32'h80000024, 1'b0, 2'b01, 1'b0, '0, 32'hFFFFF00D, 1'b0, 3, 0);
    run("ld_rsvd", 32'h80000028, 1'b0, 2'b11, 1'b0, '0, 32'h1234F00D, 1'b0, 3, 0);
    r_resp = 2'b10;
    run("ld_rerr", 32'h8000002C, 1'b0, 2'b10, 1'b0, '0, 32'h1234F00D, 1'b1, 3, 0);
    r_resp = 2'b00;

    // 3: half store, W accepted two cycles before AW
    aw_wait = 2; w_wait = 0; a0 = aw_beats; w0 = w_beats;
    run("st_half", 32'h80000100, 1'b1, 2'b01, 1'b0, 32'h0000ABCD, 32'd0, 1'b0, 5, 0);
    check("st_half_awaddr", aw_seen, 32'h80000100);
    check("st_half_wdata", w_seen, 32'h0000ABCD);
    check("st_half_wstrb", 32'(strb_seen), 32'd2);
    check("st_half_aw_beats", 32'(aw_beats - a0), 32'd1);
    check("st_half_w_beats", 32'(w_beats - w0), 32'd1);

    // Byte store, AW before W, unmasked data
    aw_wait = 0; w_wait = 1;
    run("st_byte", 32'h80000105, 1'b1, 2'b00, 1'b0, 32'hCAFE1277, 32'd0, 1'b0, 4, 0);
    check("st_byte_wdata", w_seen, 32'hCAFE1277);
    check("st_byte_wstrb", 32'(strb_seen), 32'd1);
    w_wait = 0;

    // 4: arready stall and rsp_ready held off with a pending second request
    ar_wait = 4; r_data = 32'h55AA33CC; b0 = ar_beats;
    run("ld_stall", 32'h80000200, 1'b0, 2'b10, 1'b0, '0, 32'h55AA33CC, 1'b0, 7, 3);
    ar_wait = 0;
    repeat (3) @(posedge clk);
    #1;
    check("ld_stall_beats", 32'(ar_beats - b0), 32'd1);
    check("ld_stall_araddr", ar_seen, 32'h80000200);

    // 5: bresp error on a word store
    b_resp = 2'b10;
    run("st_berr", 32'h80000300, 1'b1, 2'b10, 1'b0, 32'h01020304, 32'd0, 1'b1, 3, 0);
    check("st_berr_wstrb", 32'(strb_seen), 32'd3);
    b_resp = 2'b00;

    // 5: reset while waiting in RD_DATA
    r_stall = 1'b1;
    req_addr = 32'h80000400; req_wen = 1'b0; req_size = 2'b10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rready && n < 20) begin @(posedge clk); #1; n++; end
    check("rst_mid_reached_rd_data", 32'(rready), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valids", {29'd0, arvalid, rready, rsp_valid}, 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0; r_stall = 1'b0;
    @(posedge clk); #1;

    // 6: misaligned word load
    b0 = ar_beats; r_data = 32'h11223344;
`ifdef LSU_MISALIGN_CHECK_EN
    run("ld_misalign", 32'h80000002, 1'b0, 2'b10, 1'b0, '0, 32'd0, 1'b1, 1, 0);
    check("ld_misalign_no_ar", 32'(ar_beats - b0), 32'd0);
`else
    run("ld_misalign", 32'h80000002, 1'b0, 2'b10, 1'b0, '0, 32'h11223344, 1'b0, 3, 0);
    check("ld_misalign_araddr", ar_seen, 32'h80000002);
`endif

    // Back-to-back normal load after everything above
    r_data = 32'h0000807F;
    run("ld_byte_final", 32'h80000500, 1'b0, 2'b00, 1'b0, '0, 32'h0000007F, 1'b0, 3, 0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
